// File: rtl/adc128s022_emulator_pkg.sv
// Shared constants, FSM state type and frame-word helper for the ADC128S022 SPI slave emulator.
package adc128s022_emulator_pkg;

  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 12;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 3;
  localparam int RCNT_W     = 5;
  localparam int CNT_W      = 16;
  localparam int ADDR_RISE2 = 3;
  localparam int ADDR_RISE1 = 4;
  localparam int ADDR_RISE0 = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_W-1:0] sample);
    return {{(FRAME_BITS-DATA_W){1'b0}}, sample};
  endfunction

endpackage

// File: rtl/adc128s022_emulator_spi_edge_sync.sv
// Synchronizer chain for one asynchronous SPI pin with single-clock rise/fall pulses.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= {SYNC_STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], sig_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = chain_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adc128s022_emulator.sv
// ADC128S022 SPI slave emulator: 3-bit channel address in, {4'b0, sample} out MSB-first.
// Optional build macro ADC_EMU_PATTERN_EN adds pattern_sel for a synthetic {addr, frame count} sample.
module adc128s022_emulator
  import adc128s022_emulator_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs_n,
  input  logic                     sclk,
  input  logic                     din,
  output logic                     dout,
  output logic                     dout_oe,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
`ifdef ADC_EMU_PATTERN_EN
  input  logic                     pattern_sel,
`endif
  output logic                     frame_done,
  output logic [ADDR_W-1:0]        frame_addr,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic                     abort_err
);

  logic cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   din_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sig_i (cs_n),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sig_i (sclk),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  // din gets the same depth so its synchronized value lines up with the sclk edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_sync_q <= '0;
    else        din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
  end
  assign din_s = din_sync_q[SYNC_STAGES-1];

  state_e                  state_q, state_d;
  logic [RCNT_W-1:0]       rcnt_q, rcnt_d, rcnt_inc;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    dout_q, dout_d;
  logic                    dout_oe_q, dout_oe_d;
  logic [ADDR_W-1:0]       addr_reg_q, addr_reg_d;
  logic [ADDR_W-1:0]       addr_nxt_q, addr_nxt_d;
  logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]       frame_addr_q, frame_addr_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                    frame_done_q, frame_done_d;
  logic                    abort_q, abort_d;
  logic [ADDR_W-1:0]       load_addr;
  logic [DATA_W-1:0]       load_sample;
  logic [FRAME_BITS-1:0]   load_word;
`ifdef ADC_EMU_PATTERN_EN
  logic [7:0]              load_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (cs_fall) state_d = ACTIVE;
      ACTIVE: if (cs_rise) state_d = IDLE;
    endcase
  end

  // A frame loads from addr_reg at cs_n fall, or from the just-received address at rise 16
  always_comb begin
    load_addr   = (state_q == IDLE) ? addr_reg_q : addr_nxt_q;
    load_sample = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_addr == ADDR_W'(i)) load_sample = ch_data[i*DATA_W +: DATA_W];
    end
`ifdef ADC_EMU_PATTERN_EN
    load_cnt = (state_q == IDLE) ? frame_cnt_q[7:0] : frame_cnt_q[7:0] + 8'd1;
    if (pattern_sel) load_sample = {1'b0, load_addr, load_cnt};
`endif
    load_word = frame_word(load_sample);
  end

  assign rcnt_inc = rcnt_q + 5'd1;

  always_comb begin
    rcnt_d       = rcnt_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    dout_oe_d    = dout_oe_q;
    addr_reg_d   = addr_reg_q;
    addr_nxt_d   = addr_nxt_q;
    cur_addr_d   = cur_addr_q;
    frame_addr_d = frame_addr_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          dout_d     = load_word[FRAME_BITS-1];
          shreg_d    = {load_word[FRAME_BITS-2:0], 1'b0};
          rcnt_d     = '0;
          dout_oe_d  = 1'b1;
          cur_addr_d = addr_reg_q;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          dout_d    = 1'b0;
          dout_oe_d = 1'b0;
          rcnt_d    = '0;
          abort_d   = (rcnt_q != '0);
        end else if (sclk_rise) begin
          rcnt_d = rcnt_inc;
          if (rcnt_inc == RCNT_W'(ADDR_RISE2)) addr_nxt_d[2] = din_s;
          if (rcnt_inc == RCNT_W'(ADDR_RISE1)) addr_nxt_d[1] = din_s;
          if (rcnt_inc == RCNT_W'(ADDR_RISE0)) addr_nxt_d[0] = din_s;
          if (rcnt_inc == RCNT_W'(FRAME_BITS)) begin
            addr_reg_d   = addr_nxt_q;
            cur_addr_d   = addr_nxt_q;
            frame_addr_d = cur_addr_q;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            frame_done_d = 1'b1;
            rcnt_d       = '0;
            shreg_d      = load_word;
          end
        end else if (sclk_fall) begin
          dout_d  = shreg_q[FRAME_BITS-1];
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q       <= '0;
      shreg_q      <= '0;
      dout_q       <= 1'b0;
      dout_oe_q    <= 1'b0;
      addr_reg_q   <= '0;
      addr_nxt_q   <= '0;
      cur_addr_q   <= '0;
      frame_addr_q <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      rcnt_q       <= rcnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_oe_q    <= dout_oe_d;
      addr_reg_q   <= addr_reg_d;
      addr_nxt_q   <= addr_nxt_d;
      cur_addr_q   <= cur_addr_d;
      frame_addr_q <= frame_addr_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
    end
  end

  assign dout       = dout_q;
  assign dout_oe    = dout_oe_q;
  assign frame_done = frame_done_q;
  assign frame_addr = frame_addr_q;
  assign frame_cnt  = frame_cnt_q;
  assign abort_err  = abort_q;

endmodule
